mat_loader: RTL and testbench
=============================

Name: mat_loader

Overview:
- Front-end feeder for the systolic-free matrix multiplier datapath.
- Accepts a serial stream of signed W_IN-bit elements on a valid/ready handshake.
- Assembles two N×N operand matrices (A then B) and presents them in parallel with a single valid qualifier, gated by the multiplier's clock enable.
- Sits between the instruction/data fetch stream and the multiplier's matrix_1/matrix_2/valid_in inputs.

Parameters:
W_IN, 8, element width in bits (signed two's complement)
N, 2, matrix dimension (N×N); power of two, N >= 2

Ports:
clk  input  1  clock, all state updates on rising edge
rstn  input  1  asynchronous active-low reset
s_data  input  W_IN  signed stream element
s_valid  input  1  s_data valid
s_ready  output  1  loader can accept an element; handshake = s_valid && s_ready
cen  input  1  downstream clock enable; issue consumed on an edge where cen=1
valid_out  output  1  matrix_1/matrix_2 hold a complete operand pair
matrix_1  output  N*N*W_IN  packed [N-1:0][N-1:0][W_IN-1:0], operand A, [row][col]
matrix_2  output  N*N*W_IN  packed [N-1:0][N-1:0][W_IN-1:0], operand B, [row][col]
busy  output  1  high when a partial pair is loaded or an issue is pending

Behaviour:
- Reset (rstn low, asynchronous):
  - state=LOAD_A, idx=0.
  - matrix_1, matrix_2 all zero.
  - valid_out=0, s_ready=0, busy=0.
- s_ready is a registered output. It rises on the first clk edge after rstn deasserts.
- State LOAD_A:
  - Each handshake writes s_data to matrix_1[idx/N][idx%N] and increments idx.
  - On the handshake with idx=N*N-1: idx->0, state->LOAD_B.
- State LOAD_B:
  - Same, writing matrix_2[idx/N][idx%N] (row-major).
  - On the handshake with idx=N*N-1: idx->0, state->ISSUE.
  - On that same edge s_ready->0 and valid_out->1.
- State ISSUE:
  - valid_out=1, s_ready=0; s_valid/s_data ignored.
  - matrix_1/matrix_2 held stable.
  - On an edge with cen=1: valid_out->0, s_ready->1, state->LOAD_A.
  - With cen=0, ISSUE holds indefinitely.
- Latency and throughput:
  - valid_out asserts one cycle after the 2*N*N-th accepted element.
  - With cen=1, valid_out is high for exactly one cycle.
  - Minimum period per pair is 2*N*N+1 cycles.
- cen affects only ISSUE exit. Loading proceeds regardless of cen.
- Matrix registers are not cleared between pairs:
  - An element slot is overwritten only when its new value is accepted.
  - Outputs stay at the last issued values after valid_out drops, until overwritten.
- Stream bubbles (s_valid=0) do not advance idx.
- busy = (state != LOAD_A) || (idx != 0).
- Reset mid-load or mid-issue discards all partial data, and every output returns to its reset value immediately.
- idx width: $clog2(N*N). No arithmetic is performed; elements are stored bit-exact.

Optional Feature:
MAT_LOADER_B_COLMAJOR_EN
- Defined: operand B elements arrive column-major. The idx-th B element is written to matrix_2[idx%N][idx/N].
- Undefined: B is row-major, as above.
- Operand A is row-major in both cases. No port or timing change.

Test Plan:
- N=2, rstn released, cen=1; stream 1,2,3,4,5,6,7,8 back-to-back -> matrix_1={{1,2},{3,4}}, matrix_2={{5,6},{7,8}}; valid_out high exactly one cycle, starting the cycle after the 8th handshake; s_ready low during that cycle and high again the next.
- Same stream with cen=0 for 3 cycles after the last element -> valid_out high 4 cycles; matrices stable; s_valid=1 with data 99 during ISSUE is not accepted (s_ready=0); the next pair starts cleanly.
- Stream with bubbles (s_valid toggling 1,0,0,1,...) -> only handshakes count; final matrices identical to the first test; busy high from the first accepted element until ISSUE exits.
- Assert rstn after 5 accepted elements -> all matrices zero, valid_out=0, s_ready=0 immediately; after release, stream 9..16 loads matrix_1={{9,10},{11,12}}.
- Elements -128,127,-1,0 for A, B=0s -> matrix_1 bits 0x80,0x7F,0xFF,0x00 exactly.
- With MAT_LOADER_B_COLMAJOR_EN, B stream 5,6,7,8 -> matrix_2={{5,7},{6,8}}; A unchanged at {{1,2},{3,4}}.

Source files
------------

// File: rtl/mat_loader.sv
// Serial-to-parallel operand loader: streams A then B (N x N, signed W_IN) and issues them together.
// Build option: MAT_LOADER_B_COLMAJOR_EN makes operand B arrive column-major.
module mat_loader #(
    parameter int W_IN = 8,
    parameter int N    = 2
) (
    input  logic                              clk,
    input  logic                              rstn,
    input  logic [W_IN-1:0]                   s_data,
    input  logic                              s_valid,
    output logic                              s_ready,
    input  logic                              cen,
    output logic                              valid_out,
    output logic [N-1:0][N-1:0][W_IN-1:0]     matrix_1,
    output logic [N-1:0][N-1:0][W_IN-1:0]     matrix_2,
    output logic                              busy
);

    localparam int NN = N * N;
    localparam int IW = $clog2(NN);
    localparam int LW = $clog2(N);

    typedef enum logic [1:0] {
        LOAD_A = 2'd0,
        LOAD_B = 2'd1,
        ISSUE  = 2'd2
    } state_t;

    state_t          state_r;
    logic [IW-1:0]   idx_r;
    logic            hs_s;
    logic            last_s;
    logic [LW-1:0]   row_s;
    logic [LW-1:0]   col_s;
    logic [LW-1:0]   b_row_s;
    logic [LW-1:0]   b_col_s;

    // Handshake decode and element placement; N is a power of two so idx splits into row/col bits.
    always_comb begin
        hs_s   = s_valid && s_ready;
        last_s = (idx_r == IW'(NN - 1));
        row_s  = idx_r[IW-1:LW];
        col_s  = idx_r[LW-1:0];
`ifdef MAT_LOADER_B_COLMAJOR_EN
        b_row_s = col_s;
        b_col_s = row_s;
`else
        b_row_s = row_s;
        b_col_s = col_s;
`endif
    end

    // Loader FSM; all outputs are registered and matrices are only written on accepted elements.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_r   <= LOAD_A;
            idx_r     <= '0;
            matrix_1  <= '0;
            matrix_2  <= '0;
            valid_out <= 1'b0;
            s_ready   <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state_r)
                LOAD_A: begin
                    s_ready   <= 1'b1;
                    valid_out <= 1'b0;
                    if (hs_s) begin
                        matrix_1[row_s][col_s] <= s_data;
                        busy                   <= 1'b1;
                        if (last_s) begin
                            idx_r   <= '0;
                            state_r <= LOAD_B;
                        end else begin
                            idx_r <= idx_r + IW'(1);
                        end
                    end
                end
                LOAD_B: begin
                    busy <= 1'b1;
                    if (hs_s) begin
                        matrix_2[b_row_s][b_col_s] <= s_data;
                        if (last_s) begin
                            idx_r     <= '0;
                            state_r   <= ISSUE;
                            s_ready   <= 1'b0;
                            valid_out <= 1'b1;
                        end else begin
                            idx_r   <= idx_r + IW'(1);
                            s_ready <= 1'b1;
                        end
                    end else begin
                        s_ready <= 1'b1;
                    end
                end
                ISSUE: begin
                    // Hold the pair until the multiplier's enabled edge consumes it.
                    if (cen) begin
                        valid_out <= 1'b0;
                        s_ready   <= 1'b1;
                        busy      <= 1'b0;
                        state_r   <= LOAD_A;
                    end else begin
                        valid_out <= 1'b1;
                        s_ready   <= 1'b0;
                        busy      <= 1'b1;
                    end
                end
                default: begin
                    state_r   <= LOAD_A;
                    idx_r     <= '0;
                    valid_out <= 1'b0;
                    s_ready   <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mat_loader.sv
// Scoreboard bench for mat_loader (N=2, W_IN=8): expected pairs are queued at stimulus time, checked at issue.
module tb_mat_loader;

    logic                   clk;
    logic                   rstn;
    logic [7:0]             s_data;
    logic                   s_valid;
    logic                   s_ready;
    logic                   cen;
    logic                   valid_out;
    logic [1:0][1:0][7:0]   m1;
    logic [1:0][1:0][7:0]   m2;
    logic                   busy;

    int vectors;
    int miscompares;
    logic [63:0] exp_q[$];

    localparam logic [31:0] A_1234 = 32'h04030201;
    localparam logic [31:0] A_9_12 = 32'h0C0B0A09;
    localparam logic [31:0] A_EXT  = 32'h00FF7F80;
`ifdef MAT_LOADER_B_COLMAJOR_EN
    localparam logic [31:0] B_5678 = 32'h08060705;
    localparam logic [31:0] B_1316 = 32'h100E0F0D;
`else
    localparam logic [31:0] B_5678 = 32'h08070605;
    localparam logic [31:0] B_1316 = 32'h100F0E0D;
`endif

    mat_loader #(.W_IN(8), .N(2)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .s_data    (s_data),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .cen       (cen),
        .valid_out (valid_out),
        .matrix_1  (m1),
        .matrix_2  (m2),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic send(input logic [7:0] d);
        int k;
        s_data  = d;
        s_valid = 1'b1;
        k = 0;
        while (!s_ready && k < 50) begin
            @(posedge clk);
            #1;
            k++;
        end
        check("s_ready_wait", 64'(s_ready), 64'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: an issue is consumed on an edge where valid_out and cen are both high.
    always @(negedge clk) begin
        logic [63:0] e;
        if (rstn && valid_out && cen) begin
            if (exp_q.size() == 0) begin
                check("unexpected_issue", 64'(valid_out), 64'd0);
            end else begin
                e = exp_q.pop_front();
                check("issue_m1", 64'(m1), {32'd0, e[63:32]});
                check("issue_m2", 64'(m2), {32'd0, e[31:0]});
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        miscompares++;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $fatal(1, "watchdog");
    end

    initial begin
        vectors     = 0;
        miscompares = 0;
        rstn    = 1'b0;
        cen     = 1'b1;
        s_valid = 1'b0;
        s_data  = 8'd0;
        #12;
        check("rst_valid", 64'(valid_out), 64'd0);
        check("rst_ready", 64'(s_ready), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_m1", 64'(m1), 64'd0);
        check("rst_m2", 64'(m2), 64'd0);
        tick();
        rstn = 1'b1;
        check("ready_after_release", 64'(s_ready), 64'd0);
        tick();
        check("ready_rises", 64'(s_ready), 64'd1);

        // Back-to-back pair, cen=1: one-cycle issue.
        exp_q.push_back({A_1234, B_5678});
        for (int i = 1; i <= 8; i++) send(8'(i));
        s_valid = 1'b0;
        check("t1_valid_hi", 64'(valid_out), 64'd1);
        check("t1_ready_lo", 64'(s_ready), 64'd0);
        tick();
        check("t1_valid_drop", 64'(valid_out), 64'd0);
        check("t1_ready_back", 64'(s_ready), 64'd1);

        // cen held low for 3 cycles: issue stretches, data 99 rejected.
        cen = 1'b0;
        exp_q.push_back({A_1234, B_5678});
        for (int i = 1; i <= 8; i++) send(8'(i));
        s_data = 8'd99;
        for (int i = 0; i < 3; i++) begin
            check("t2_valid_hold", 64'(valid_out), 64'd1);
            check("t2_ready_lo", 64'(s_ready), 64'd0);
            check("t2_busy", 64'(busy), 64'd1);
            tick();
        end
        check("t2_valid_4th", 64'(valid_out), 64'd1);
        cen = 1'b1;
        tick();
        s_valid = 1'b0;
        check("t2_valid_drop", 64'(valid_out), 64'd0);
        check("t2_m1_stable", 64'(m1), {32'd0, A_1234});
        check("t2_m2_stable", 64'(m2), {32'd0, B_5678});

        // Reset after 5 accepted elements discards everything at once.
        for (int i = 31; i <= 35; i++) send(8'(i));
        s_valid = 1'b0;
        #3;
        rstn = 1'b0;
        #1;
        check("t4_m1_zero", 64'(m1), 64'd0);
        check("t4_m2_zero", 64'(m2), 64'd0);
        check("t4_valid", 64'(valid_out), 64'd0);
        check("t4_ready", 64'(s_ready), 64'd0);
        check("t4_busy", 64'(busy), 64'd0);
        tick();
        rstn = 1'b1;
        exp_q.push_back({A_9_12, B_1316});
        for (int i = 9; i <= 16; i++) send(8'(i));
        s_valid = 1'b0;
        tick();

        // Extreme signed values stored bit-exact.
        exp_q.push_back({A_EXT, 32'd0});
        send(8'h80); send(8'h7F); send(8'hFF); send(8'h00);
        for (int i = 0; i < 4; i++) send(8'h00);
        s_valid = 1'b0;
        tick();
        check("t5_m1_after", 64'(m1), {32'd0, A_EXT});

        // Bubbles between elements; busy tracks the partial pair.
        check("t3_busy_idle", 64'(busy), 64'd0);
        exp_q.push_back({A_1234, B_5678});
        for (int i = 0; i < 8; i++) begin
            send(8'(i + 1));
            s_valid = 1'b0;
            check("t3_busy_hi", 64'(busy), 64'd1);
            if (i < 7) begin
                tick();
                tick();
            end
        end
        tick();
        check("t3_busy_done", 64'(busy), 64'd0);
        check("t3_valid_done", 64'(valid_out), 64'd0);

        tick();
        tick();
        check("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
